shift_pipe_stage: RTL and testbench

SHIFT_PIPE_STAGE -- requirements
Module: shift_pipe_stage

---
 rtl/shift_pipe_stage.sv | 130 +++++++++++++
 tb/tb_shift_pipe_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_stage.sv
// rtl/shift_pipe_stage.sv - two-register pipelined shifter stage with valid/ready handshake
// Optional registered result flags (out_zero, out_neg) are enabled by SHIFT_PIPE_FLAGS_EN.
module shift_pipe_stage #(
  parameter int DATA_WIDTH         = 32,
  parameter int SHIFT_WIDTH        = $clog2(DATA_WIDTH),
  parameter int TAG_WIDTH          = 5,
  parameter int SHIFT_OPCODE_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHIFT_OPCODE_WIDTH-1:0] in_mode,
  input  logic [SHIFT_WIDTH-1:0]        in_shift_amt,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [TAG_WIDTH-1:0]          out_tag,
`ifdef SHIFT_PIPE_FLAGS_EN
  output logic                          out_zero,
  output logic                          out_neg,
`endif
  output logic                          busy
);

  localparam logic [SHIFT_OPCODE_WIDTH-1:0] OP_LLOG = SHIFT_OPCODE_WIDTH'(0);
  localparam logic [SHIFT_OPCODE_WIDTH-1:0] OP_RLOG = SHIFT_OPCODE_WIDTH'(1);
  localparam logic [SHIFT_OPCODE_WIDTH-1:0] OP_LROT = SHIFT_OPCODE_WIDTH'(2);
  localparam logic [SHIFT_OPCODE_WIDTH-1:0] OP_RROT = SHIFT_OPCODE_WIDTH'(3);
  localparam logic [SHIFT_OPCODE_WIDTH-1:0] OP_RAR  = SHIFT_OPCODE_WIDTH'(4);

  logic                          s1_valid;
  logic [SHIFT_OPCODE_WIDTH-1:0] s1_mode;
  logic [SHIFT_WIDTH-1:0]        s1_amt;
  logic [DATA_WIDTH-1:0]         s1_data;
  logic [TAG_WIDTH-1:0]          s1_tag;

  logic                          s2_valid;
  logic [DATA_WIDTH-1:0]         s2_data;
  logic [TAG_WIDTH-1:0]          s2_tag;

  logic                          s1_adv;
  logic                          accept;
  logic                          out_fire;
  logic [DATA_WIDTH-1:0]         shift_result;

  // Rotations by zero rely on a full-width shift producing zero for the wrap term.
  always_comb begin
    shift_result = s1_data;
    case (s1_mode)
      OP_LLOG: shift_result = s1_data << s1_amt;
      OP_RLOG: shift_result = s1_data >> s1_amt;
      OP_LROT: shift_result = (s1_data << s1_amt) | (s1_data >> (DATA_WIDTH - int'(s1_amt)));
      OP_RROT: shift_result = (s1_data >> s1_amt) | (s1_data << (DATA_WIDTH - int'(s1_amt)));
      OP_RAR:  shift_result = $signed(s1_data) >>> s1_amt;
      default: shift_result = s1_data;
    endcase
  end

  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !flush && (!s1_valid || s1_adv);
  assign accept    = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign busy      = s1_valid || s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_amt   <= '0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      s1_amt   <= in_shift_amt;
      s1_data  <= in_data;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef SHIFT_PIPE_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= shift_result;
      s2_tag   <= s1_tag;
      out_zero <= (shift_result == '0);
      out_neg  <= shift_result[DATA_WIDTH-1];
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= shift_result;
      s2_tag   <= s1_tag;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipe_stage.sv
// tb/tb_shift_pipe_stage.sv - scoreboard bench for shift_pipe_stage
// Directed scenarios followed by randomized traffic against an arithmetic shift model.
module tb_shift_pipe_stage;

  localparam logic [2:0] LLOG = 3'd0, RLOG = 3'd1, LROT = 3'd2, RROT = 3'd3, RAR = 3'd4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_mode;
  logic [4:0]  in_shift_amt, in_tag, out_tag;
  logic [31:0] in_data, out_data;
`ifdef SHIFT_PIPE_FLAGS_EN
  logic        out_zero, out_neg;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];

  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [4:0]  prev_tag   = '0;

  shift_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_shift_amt(in_shift_amt), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
`ifdef SHIFT_PIPE_FLAGS_EN
    .out_zero(out_zero), .out_neg(out_neg),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [2:0] m, input int a, input logic [31:0] d);
    longint unsigned u  = 64'(d);
    longint          s  = longint'($signed(d));
    longint          p  = longint'(1) << a;
    logic [63:0]     dd = {d, d};
    case (m)
      LLOG: return 32'(u * 64'(p));
      RLOG: return 32'(u / 64'(p));
      LROT: begin dd = dd << a; return dd[63:32]; end
      RROT: begin dd = dd >> a; return dd[31:0]; end
      RAR:  return 32'((s >= 0) ? s / p : -((-s + p - 1) / p));
      default: return d;
    endcase
  endfunction

  // Monitor samples one time unit before each rising edge.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      check("busy_vs_model", 64'(busy), 64'(sb.size() != 0));
      if (prev_stall && !prev_flush) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (flush) check("flush_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          e = sb.pop_front();
          check("sb_data", 64'(out_data), 64'(e.data));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
`ifdef SHIFT_PIPE_FLAGS_EN
          check("sb_neg", 64'(out_neg), 64'(e.data[31]));
          check("sb_zero", 64'(out_zero), 64'(e.data == 32'd0));
`endif
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back('{ref_shift(in_mode, int'(in_shift_amt), in_data), in_tag});
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  task automatic send(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d, input logic [4:0] t);
    bit done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_shift_amt = a; in_data = d; in_tag = t;
    for (int i = 0; i < 40 && !done; i++) begin
      #3;
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_shift_amt = '0; in_data = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Two-cycle latency on a single RLOG.
    send(RLOG, 5'd4, 32'h0000_00F0, 5'd3);
    idle();
    check("lat_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'h0000_000F);
    check("lat_tag", 64'(out_tag), 64'd3);
    wait_idle("idle_after_lat");

    // Back-to-back ops drain on consecutive cycles.
    send(RROT, 5'd8, 32'h1234_5678, 5'd1);
    send(LLOG, 5'd1, 32'h8000_0001, 5'd2);
    idle();
    check("b2b_first", 64'(out_data), 64'h7812_3456);
    @(negedge clk);
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second", 64'(out_data), 64'h0000_0002);
    wait_idle("idle_after_b2b");

    // Backpressure: two accepted, third held off until release.
    out_ready = 1'b0;
    send(LROT, 5'd4, 32'hF000_000A, 5'd4);
    send(RLOG, 5'd1, 32'h0000_0010, 5'd5);
    @(negedge clk);
    in_valid = 1'b1; in_mode = LLOG; in_shift_amt = 5'd0; in_data = 32'h0000_0055; in_tag = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", 64'(out_data), 64'h0000_00AF);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
        #3;
        if (in_ready) begin
          @(posedge clk);
          ok = 1;
        end else begin
          @(negedge clk);
        end
      end
      check("bp_third_accepted", 64'(ok), 64'd1);
    end
    idle();
    wait_idle("idle_after_bp");

    // Flush with both stages full.
    out_ready = 1'b0;
    send(LLOG, 5'd3, 32'h0000_0011, 5'd7);
    send(RLOG, 5'd2, 32'h0000_0100, 5'd8);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; in_mode = LLOG; in_shift_amt = 5'd1; in_data = 32'h1; in_tag = 5'd9;
    #3;
    check("flush_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready_after", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Arithmetic shift of the sign bit and an unknown opcode.
    send(RAR, 5'd31, 32'h8000_0000, 5'd10);
    send(3'd5, 5'd9, 32'hDEAD_BEEF, 5'd11);
    idle();
    check("rar_data", 64'(out_data), 64'hFFFF_FFFF);
`ifdef SHIFT_PIPE_FLAGS_EN
    check("rar_neg", 64'(out_neg), 64'd1);
    check("rar_zero", 64'(out_zero), 64'd0);
`endif
    @(negedge clk);
    check("unknown_passthru", 64'(out_data), 64'hDEAD_BEEF);
    wait_idle("idle_after_rar");

    // Asynchronous reset while S2 holds a result.
    out_ready = 1'b0;
    send(LLOG, 5'd4, 32'h0000_0123, 5'd12);
    idle();
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with backpressure and occasional flush.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 4) != 0) begin
        in_valid     = 1'b1;
        in_mode      = 3'($urandom_range(0, 7));
        in_shift_amt = 5'($urandom_range(0, 31));
        in_data      = $urandom;
        in_tag       = 5'($urandom_range(0, 31));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_idle("idle_after_random");
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
